md_hilo_unit: RTL and testbench

//  Parametrised multiply/divide engine with its own HI/LO architectural registers. Serves MULT/MULTU/DIV/DIVU,

---
 rtl/md_hilo_unit.sv | 174 +++++++++++++++++
 tb/tb_md_hilo_unit.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/md_hilo_unit.sv
// Multiply/divide engine with private HI/LO registers, MF read port, MT write port and decode-stage stall.
// MULT* run through a MUL_LAT-deep product pipe; DIV* run a restoring radix-2 divider on magnitudes plus one sign-fix cycle.
module md_hilo_unit #(
    parameter int XLEN    = 32,
    parameter int MUL_LAT = 3
) (
    input  logic            clk,
    input  logic            clrn,
    input  logic            start_i,
    input  logic [1:0]      op_i,
    input  logic [XLEN-1:0] src_a_i,
    input  logic [XLEN-1:0] src_b_i,
    input  logic            mthi_i,
    input  logic            mtlo_i,
    input  logic [XLEN-1:0] mt_data_i,
    input  logic            mfhi_i,
    input  logic            mflo_i,
    input  logic            flush_i,
    output logic            busy_o,
    output logic            stall_o,
    output logic            done_o,
    output logic [XLEN-1:0] rdata_o,
    output logic [XLEN-1:0] hi_o,
    output logic [XLEN-1:0] lo_o
);
    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_e;

    localparam int CNT_MAX = (XLEN > MUL_LAT) ? XLEN : MUL_LAT;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] MUL_LAST = CW'(MUL_LAT - 1);
    localparam logic [CW-1:0] DIV_LAST = CW'(XLEN - 1);

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [XLEN-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic              done_q, done_d;
    logic [2*XLEN-1:0] pipe_q [MUL_LAT];
    logic [XLEN-1:0]   quo_q, rem_q, dvs_q, dvd_q;
    logic              qneg_q, rneg_q, dvz_q;

    logic              accept, wr_mul, wr_div, busy;
    logic              op_signed, a_neg, b_neg;
    logic [XLEN-1:0]   a_mag, b_mag, quo_fix, rem_fix;
    logic [2*XLEN-1:0] ext_a, ext_b, product;
    logic [XLEN:0]     shifted, diff;

    assign busy      = (state_q != S_IDLE);
    assign op_signed = ~op_i[0];
    assign a_neg     = op_signed & src_a_i[XLEN-1];
    assign b_neg     = op_signed & src_b_i[XLEN-1];
    assign a_mag     = a_neg ? -src_a_i : src_a_i;
    assign b_mag     = b_neg ? -src_b_i : src_b_i;
    // Sign- or zero-extending to 2*XLEN makes one unsigned multiply correct for both flavours.
    assign ext_a     = {{XLEN{a_neg}}, src_a_i};
    assign ext_b     = {{XLEN{b_neg}}, src_b_i};
    assign product   = ext_a * ext_b;

    assign shifted   = {rem_q, quo_q[XLEN-1]};
    assign diff      = shifted - {1'b0, dvs_q};
    assign quo_fix   = qneg_q ? -quo_q : quo_q;
    assign rem_fix   = rneg_q ? -rem_q : rem_q;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        wr_mul  = 1'b0;
        wr_div  = 1'b0;
        case (state_q)
            S_IDLE: if (start_i) begin
                accept  = 1'b1;
                cnt_d   = '0;
                state_d = op_i[1] ? S_DIV : S_MUL;
            end
            S_MUL: if (cnt_q == MUL_LAST) begin
                wr_mul  = 1'b1;
                cnt_d   = '0;
                state_d = S_IDLE;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
            S_DIV: if (cnt_q == DIV_LAST) begin
                cnt_d   = '0;
                state_d = S_FIX;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
            S_FIX: begin
                wr_div  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (flush_i) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            accept  = 1'b0;
            wr_mul  = 1'b0;
            wr_div  = 1'b0;
        end

        hi_d = hi_q;
        lo_d = lo_q;
        if (!busy && !flush_i) begin
            if (mthi_i) hi_d = mt_data_i;
            if (mtlo_i) lo_d = mt_data_i;
        end
        if (wr_mul) {hi_d, lo_d} = pipe_q[MUL_LAT-1];
        if (wr_div) begin
            hi_d = dvz_q ? dvd_q : rem_fix;
            lo_d = dvz_q ? {XLEN{1'b1}} : quo_fix;
        end
        done_d = wr_mul | wr_div;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    // NOTE: the product pipe is a handful of flops, not RAM, so it is cleared with the rest of the state.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            for (int i = 0; i < MUL_LAT; i++) pipe_q[i] <= '0;
            quo_q  <= '0;
            rem_q  <= '0;
            dvs_q  <= '0;
            dvd_q  <= '0;
            qneg_q <= 1'b0;
            rneg_q <= 1'b0;
            dvz_q  <= 1'b0;
        end else begin
            if (accept && !op_i[1]) pipe_q[0] <= product;
            for (int i = 1; i < MUL_LAT; i++) pipe_q[i] <= pipe_q[i-1];
            if (accept && op_i[1]) begin
                quo_q  <= a_mag;
                rem_q  <= '0;
                dvs_q  <= b_mag;
                dvd_q  <= src_a_i;
                qneg_q <= a_neg ^ b_neg;
                rneg_q <= a_neg;
                dvz_q  <= (src_b_i == '0);
            end else if (state_q == S_DIV && !flush_i) begin
                if (!diff[XLEN]) begin
                    rem_q <= diff[XLEN-1:0];
                    quo_q <= {quo_q[XLEN-2:0], 1'b1};
                end else begin
                    rem_q <= shifted[XLEN-1:0];
                    quo_q <= {quo_q[XLEN-2:0], 1'b0};
                end
            end
        end
    end

    assign busy_o  = busy;
    assign stall_o = busy & (start_i | mthi_i | mtlo_i | mfhi_i | mflo_i);
    assign done_o  = done_q;
    assign rdata_o = mfhi_i ? hi_q : (mflo_i ? lo_q : '0);
    assign hi_o    = hi_q;
    assign lo_o    = lo_q;
endmodule

// File: tb/tb_md_hilo_unit.sv
// Self-checking bench for md_hilo_unit: directed scenarios plus randomized ops against an arithmetic reference model.
module tb_md_hilo_unit;
    localparam int XLEN    = 32;
    localparam int MUL_LAT = 3;
    localparam int DIV_LAT = XLEN + 1;

    logic            clk = 1'b0;
    logic            clrn;
    logic            start_i, mthi_i, mtlo_i, mfhi_i, mflo_i, flush_i;
    logic [1:0]      op_i;
    logic [XLEN-1:0] src_a_i, src_b_i, mt_data_i;
    logic            busy_o, stall_o, done_o;
    logic [XLEN-1:0] rdata_o, hi_o, lo_o;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_hi, exp_lo;

    md_hilo_unit #(.XLEN(XLEN), .MUL_LAT(MUL_LAT)) dut (
        .clk(clk), .clrn(clrn), .start_i(start_i), .op_i(op_i),
        .src_a_i(src_a_i), .src_b_i(src_b_i), .mthi_i(mthi_i), .mtlo_i(mtlo_i),
        .mt_data_i(mt_data_i), .mfhi_i(mfhi_i), .mflo_i(mflo_i), .flush_i(flush_i),
        .busy_o(busy_o), .stall_o(stall_o), .done_o(done_o), .rdata_o(rdata_o),
        .hi_o(hi_o), .lo_o(lo_o)
    );

    always #5 clk = ~clk;

    // Reference: {HI, LO} computed with plain 64-bit arithmetic.
    function automatic logic [63:0] ref_model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        case (op)
            2'b00: begin sa = $signed(a); sb = $signed(b); q = sa * sb; return q; end
            2'b01: return {32'd0, a} * {32'd0, b};
            default: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                if (op == 2'b10) begin sa = $signed(a); sb = $signed(b); end
                else begin sa = longint'({32'd0, a}); sb = longint'({32'd0, b}); end
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
        endcase
    endfunction

    task automatic tick();
        @(posedge clk); #1;
    endtask

    // Launch one op, scramble operands after acceptance, wait (bounded) for done_o.
    task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output int nbusy, output logic [31:0] h,
                         output logic [31:0] l, output logic pulse_ok);
        start_i = 1'b1; op_i = op; src_a_i = a; src_b_i = b;
        tick();
        start_i = 1'b0; src_a_i = $urandom; src_b_i = $urandom;
        lat = 0; nbusy = 0;
        while (!done_o && lat < 200) begin
            if (busy_o) nbusy++;
            tick();
            lat++;
        end
        h = hi_o; l = lo_o;
        tick();
        pulse_ok = !done_o && !busy_o;
    endtask

    task automatic test_reset();
        clrn = 1'b0;
        #12;
        n_checks++;
        if ({busy_o, stall_o, done_o, hi_o, lo_o, rdata_o} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: busy=%b stall=%b done=%b hi=%h lo=%h rdata=%h, required all 0",
                     busy_o, stall_o, done_o, hi_o, lo_o, rdata_o);
        end
        tick();
        clrn = 1'b1;
        exp_hi = 0; exp_lo = 0;
        tick();
    endtask

    task automatic run_table(input string name, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        int lat, nbusy, want_lat;
        logic [31:0] h, l;
        logic pulse_ok;
        logic [63:0] e;
        e = ref_model(op, a, b);
        want_lat = op[1] ? DIV_LAT : MUL_LAT;
        do_op(op, a, b, lat, nbusy, h, l, pulse_ok);
        n_checks++;
        if (lat !== want_lat || nbusy !== want_lat) begin
            n_fail++;
            $display("FAIL %s_latency: done after %0d cycles, busy %0d cycles, required %0d", name, lat, nbusy, want_lat);
        end
        n_checks++;
        if ({h, l} !== e) begin
            n_fail++;
            $display("FAIL %s_result: HI=%h LO=%h, required HI=%h LO=%h", name, h, l, e[63:32], e[31:0]);
        end
        n_checks++;
        if (pulse_ok !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_done_pulse: done/busy still high after pulse, required single pulse", name);
        end
        exp_hi = e[63:32]; exp_lo = e[31:0];
    endtask

    task automatic test_mult();
        run_table("mult_neg2x3", 2'b00, 32'hFFFF_FFFE, 32'd3);
        run_table("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_table("mult_minxmin", 2'b00, 32'h8000_0000, 32'h8000_0000);
        run_table("mult_7xneg5", 2'b00, 32'd7, 32'hFFFF_FFFB);
    endtask

    task automatic test_div();
        run_table("divu_100_7", 2'b11, 32'd100, 32'd7);
        run_table("div_neg7_2", 2'b10, 32'hFFFF_FFF9, 32'd2);
        run_table("div_7_neg2", 2'b10, 32'd7, 32'hFFFF_FFFE);
        run_table("div_min_neg1", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        run_table("divu_5_0", 2'b11, 32'd5, 32'd0);
        run_table("div_neg9_0", 2'b10, 32'hFFFF_FFF7, 32'd0);
        run_table("divu_max_1", 2'b11, 32'hFFFF_FFFF, 32'd1);
    endtask

    task automatic test_mf_forward();
        logic [63:0] e;
        int bad, k;
        e = ref_model(2'b00, 32'h0000_1234, 32'hFFFF_FFF0);
        start_i = 1'b1; op_i = 2'b00; src_a_i = 32'h0000_1234; src_b_i = 32'hFFFF_FFF0;
        tick();
        start_i = 1'b0;
        tick();
        mflo_i = 1'b1;
        #1;
        bad = 0; k = 0;
        while (!done_o && k < 50) begin
            if (stall_o !== 1'b1) bad++;
            tick();
            k++;
        end
        n_checks++;
        if (bad != 0 || k != MUL_LAT - 1) begin
            n_fail++;
            $display("FAIL mf_stall: %0d unstalled busy cycles over %0d cycles, required 0 over %0d", bad, k, MUL_LAT - 1);
        end
        n_checks++;
        if (stall_o !== 1'b0 || rdata_o !== e[31:0]) begin
            n_fail++;
            $display("FAIL mf_forward: stall=%b rdata=%h, required stall=0 rdata=%h", stall_o, rdata_o, e[31:0]);
        end
        mflo_i = 1'b0;
        exp_hi = e[63:32]; exp_lo = e[31:0];
        tick();
    endtask

    task automatic test_mt();
        logic [31:0] old_hi;
        int k;
        // MT and MF in the same idle cycle: old value read, new value lands at the edge.
        old_hi = exp_hi;
        mthi_i = 1'b1; mfhi_i = 1'b1; mt_data_i = 32'hCAFE_0001;
        #1;
        n_checks++;
        if (rdata_o !== old_hi) begin
            n_fail++;
            $display("FAIL mf_mt_same_cycle: rdata=%h, required old HI %h", rdata_o, old_hi);
        end
        tick();
        mthi_i = 1'b0; mfhi_i = 1'b0;
        mtlo_i = 1'b1; mt_data_i = 32'hBEEF_0002;
        tick();
        mtlo_i = 1'b0;
        n_checks++;
        if (hi_o !== 32'hCAFE_0001 || lo_o !== 32'hBEEF_0002) begin
            n_fail++;
            $display("FAIL mt_idle: HI=%h LO=%h, required HI=cafe0001 LO=beef0002", hi_o, lo_o);
        end
        // MTHI while a divide is running is held off.
        start_i = 1'b1; op_i = 2'b11; src_a_i = 32'd50; src_b_i = 32'd3;
        tick();
        start_i = 1'b0;
        mthi_i = 1'b1; mt_data_i = 32'h0000_1234;
        #1;
        n_checks++;
        if (stall_o !== 1'b1) begin
            n_fail++;
            $display("FAIL mt_busy_stall: stall=%b, required 1", stall_o);
        end
        for (int i = 0; i < 4; i++) tick();
        mthi_i = 1'b0;
        n_checks++;
        if (hi_o !== 32'hCAFE_0001) begin
            n_fail++;
            $display("FAIL mt_busy_ignored: HI=%h, required cafe0001", hi_o);
        end
        k = 0;
        while (!done_o && k < 100) begin tick(); k++; end
        n_checks++;
        if (hi_o !== 32'd2 || lo_o !== 32'd16) begin
            n_fail++;
            $display("FAIL mt_busy_result: HI=%h LO=%h, required HI=2 LO=16", hi_o, lo_o);
        end
        tick();
        // Start with MTLO in the same idle cycle: MT lands now, product overwrites later.
        start_i = 1'b1; op_i = 2'b01; src_a_i = 32'd3; src_b_i = 32'd4;
        mtlo_i = 1'b1; mt_data_i = 32'h5A5A_5A5A;
        tick();
        start_i = 1'b0; mtlo_i = 1'b0;
        n_checks++;
        if (lo_o !== 32'h5A5A_5A5A) begin
            n_fail++;
            $display("FAIL mt_with_start_now: LO=%h, required 5a5a5a5a", lo_o);
        end
        k = 0;
        while (!done_o && k < 100) begin tick(); k++; end
        n_checks++;
        if (hi_o !== 32'd0 || lo_o !== 32'd12) begin
            n_fail++;
            $display("FAIL mt_with_start_later: HI=%h LO=%h, required HI=0 LO=c", hi_o, lo_o);
        end
        exp_hi = 0; exp_lo = 12;
        tick();
    endtask

    task automatic test_flush();
        int pulses;
        start_i = 1'b1; op_i = 2'b10; src_a_i = 32'd1000; src_b_i = 32'd9;
        tick();
        start_i = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        n_checks++;
        if (busy_o !== 1'b0 || hi_o !== exp_hi || lo_o !== exp_lo) begin
            n_fail++;
            $display("FAIL flush_abort: busy=%b HI=%h LO=%h, required busy=0 HI=%h LO=%h",
                     busy_o, hi_o, lo_o, exp_hi, exp_lo);
        end
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            if (done_o) pulses++;
            tick();
        end
        n_checks++;
        if (pulses != 0 || hi_o !== exp_hi || lo_o !== exp_lo) begin
            n_fail++;
            $display("FAIL flush_no_done: %0d done pulses HI=%h LO=%h, required 0 and unchanged", pulses, hi_o, lo_o);
        end
        start_i = 1'b1; flush_i = 1'b1; op_i = 2'b00; src_a_i = 32'd5; src_b_i = 32'd5;
        tick();
        start_i = 1'b0; flush_i = 1'b0;
        n_checks++;
        if (busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_drops_start: busy=%b, required 0", busy_o);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        start_i = 1'b1; op_i = 2'b10; src_a_i = 32'd77; src_b_i = 32'd5;
        tick();
        start_i = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        mfhi_i = 1'b1;
        clrn = 1'b0;
        #1;
        n_checks++;
        if ({busy_o, stall_o, done_o, hi_o, lo_o, rdata_o} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_op: busy=%b stall=%b done=%b hi=%h lo=%h rdata=%h, required all 0",
                     busy_o, stall_o, done_o, hi_o, lo_o, rdata_o);
        end
        mfhi_i = 1'b0;
        tick();
        clrn = 1'b1;
        exp_hi = 0; exp_lo = 0;
        tick();
        run_table("multu_after_reset", 2'b01, 32'd2, 32'd3);
    endtask

    task automatic test_random();
        logic [1:0] op;
        logic [31:0] a, b;
        for (int n = 0; n < 24; n++) begin
            op = 2'($urandom_range(0, 3));
            a = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 15));
                2: b = 32'hFFFF_FFFF;
                default: b = $urandom;
            endcase
            run_table("random_op", op, a, b);
        end
    endtask

    initial begin
        start_i = 0; mthi_i = 0; mtlo_i = 0; mfhi_i = 0; mflo_i = 0; flush_i = 0;
        op_i = 0; src_a_i = 0; src_b_i = 0; mt_data_i = 0;
        test_reset();
        test_mult();
        test_div();
        test_mf_forward();
        test_mt();
        test_flush();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
